// File: rtl/mux_sel_rr_if.sv
// Downstream sample stream of the round-robin select sequencer.
// The master (sequencer) presents a sampled mux output with its channel tag.
// The slave (consumer) accepts it with out_ready.
interface mux_sel_rr_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic [2:0] out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/mux_sel_rr.sv
// Round-robin select sequencer for an 8:1, 3-bit channel mux.
// It grants one requesting channel at a time and drives the mux select s.
// It waits SETTLE_CYC cycles and then captures the mux output y_in.
// The captured sample is presented downstream with its channel tag.
// The select s stays frozen for the whole transaction.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no transaction; s keeps its last value; waiting for any req
//   SAMPLE | s frozen, settle counter running; req and out_ready ignored
//   HOLD   | sample presented (out_valid=1); waiting for out_ready
module mux_sel_rr #(
  parameter int unsigned SETTLE_CYC = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [2:0]  y_in,
  output logic [2:0]  s,
  output logic        busy,
  mux_sel_rr_if.master stream
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // The counter is loaded with SETTLE_CYC-1, so the capture lands exactly
  // SETTLE_CYC edges after the edge that changed s.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] s_nxt;
  logic       valid_q, valid_nxt;
  logic [2:0] data_q, data_nxt;
  logic [2:0] ch_q, ch_nxt;
  logic       busy_nxt;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_ch    = ch_q;

  // Round-robin pick: scan last+1 .. last+8 (mod 8); last itself comes last.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every registered value defaults to hold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    s_nxt     = s;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    ch_nxt    = ch_q;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|req) begin
          s_nxt     = winner;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          data_nxt  = y_in;
          ch_nxt    = s;
          valid_nxt = 1'b1;
          last_nxt  = s;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        // out_valid is always high here, so out_ready alone marks the handshake.
        // last was already updated at capture, so winner reflects the new pointer.
        if (stream.out_ready) begin
          valid_nxt = 1'b0;
          if (|req) begin
            s_nxt     = winner;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SAMPLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset drops any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 3'd7;
      s       <= 3'd0;
      valid_q <= 1'b0;
      data_q  <= 3'd0;
      ch_q    <= 3'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      s       <= s_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      ch_q    <= ch_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule
